chip_link_tx: RTL and testbench

- Chip-boundary transmitter on the chip side of the NoC-to-chip mux.
- Accepts muxed words {sel, flit} from the mux output (data_out_wr/data_out) into a small send FIFO and drives send_fifo_full back to the mux.
- Serializes each word into PW-bit phits on a narrow inter-chip link.
- Word-level flow control uses credits returned by the remote chip's receiver.

---
 rtl/chip_link_tx.sv | 176 +++++++++++++++++
 tb/tb_chip_link_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_link_tx.sv
// Purpose: chip-boundary transmitter. Buffers muxed {sel, flit} words in a small send FIFO and
//          serialises each one into PW-bit phits, least-significant first, on a credit-controlled link.
// Latency: word written at edge E0 gives its first phit valid after E1; sustained rate is one word per NP cycles.
// Backpressure: send_fifo_full is raised at occupancy >= DEPTH-1, and a word starts only when credit > 0.
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   data_out_wr, data_out[WW]        word write strobe and word {sel, flit} from the mux
//   send_fifo_full                   back-pressure to the mux (combinational from occupancy)
//   link_valid/sof/eof, link_phit    phit stream to the remote chip
//   link_credit_in                   one pulse returns one remote word slot
//   link_credit_cnt[CW]              current credit count
//   link_err                         sticky: FIFO overflow or credit overflow
module chip_link_tx #(
  parameter int FW          = 64,
  parameter int CONNECT     = 2,
  parameter int PW          = 16,
  parameter int SB          = 2,
  parameter int LINK_CREDIT = 4,
  localparam int SW = (CONNECT > 1) ? $clog2(CONNECT) : 1,
  localparam int WW = FW + SW,
  localparam int NP = (WW + PW - 1) / PW,
  localparam int CW = $clog2(LINK_CREDIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data_out_wr,
  input  logic [WW-1:0] data_out,
  output logic          send_fifo_full,
  output logic          link_valid,
  output logic          link_sof,
  output logic          link_eof,
  output logic [PW-1:0] link_phit,
  input  logic          link_credit_in,
  output logic [CW-1:0] link_credit_cnt,
  output logic          link_err
);
  localparam int DEPTH = 2 ** SB;
  localparam int SRW   = NP * PW;
  localparam int PCW   = (NP > 1) ? $clog2(NP) : 1;

  localparam logic [SB:0]    OCC_FULL = (SB + 1)'(DEPTH);
  localparam logic [SB:0]    OCC_HIGH = (SB + 1)'(DEPTH - 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(LINK_CREDIT);
  localparam logic [PCW-1:0] PC_LAST  = PCW'(NP - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;
  state_t r_state, w_state_nxt;

  logic [WW-1:0]  r_mem [DEPTH];
  logic [SB-1:0]  r_wptr, r_rptr;
  logic [SB:0]    r_occ;
  logic [SRW-1:0] r_shift;
  logic [PCW-1:0] r_pc;
  logic [CW-1:0]  r_credit;
  logic           r_valid, r_sof, r_eof, r_err;
  logic [PW-1:0]  r_phit;

  logic           w_empty, w_wr_ok, w_wr_drop;
  logic           w_pop, w_shift, w_stop;
  logic [SRW-1:0] w_head_pad;

  assign w_empty        = (r_occ == '0);
  assign send_fifo_full = (r_occ >= OCC_HIGH);
  assign w_wr_ok        = data_out_wr && (r_occ != OCC_FULL);
  assign w_wr_drop      = data_out_wr && (r_occ == OCC_FULL);
  // Head word zero-extended so the unused top of the last phit reads as zero.
  assign w_head_pad     = SRW'(r_mem[r_rptr]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && (r_credit != '0)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (r_pc != PC_LAST) begin
          w_shift = 1'b1;
        end else if (!w_empty && ((r_credit != '0) || link_credit_in)) begin
          // Last phit on the wire: chain the next word with no bubble, counting
          // a credit that arrives this very cycle.
          w_pop = 1'b1;
        end else begin
          w_stop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A credit is spent when a word's first phit is launched (the pop).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit <= CRED_MAX;
      r_err    <= 1'b0;
    end else begin
      if (w_pop && !link_credit_in) begin
        r_credit <= r_credit - 1'b1;
      end else if (!w_pop && link_credit_in) begin
        if (r_credit == CRED_MAX) r_err <= 1'b1;
        else                      r_credit <= r_credit + 1'b1;
      end
      if (w_wr_drop) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_phit  <= '0;
      r_pc    <= '0;
      r_shift <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_sof   <= 1'b1;
      r_eof   <= (NP == 1);
      r_phit  <= w_head_pad[PW-1:0];
      r_shift <= w_head_pad >> PW;
      r_pc    <= '0;
    end else if (w_shift) begin
      r_valid <= 1'b1;
      r_sof   <= 1'b0;
      r_eof   <= ((r_pc + 1'b1) == PC_LAST);
      r_phit  <= r_shift[PW-1:0];
      r_shift <= r_shift >> PW;
      r_pc    <= r_pc + 1'b1;
    end else if (w_stop) begin
      // link_phit keeps its last value; the receiver ignores it while invalid.
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end
  end

  assign link_valid      = r_valid;
  assign link_sof        = r_sof;
  assign link_eof        = r_eof;
  assign link_phit       = r_phit;
  assign link_credit_cnt = r_credit;
  assign link_err        = r_err;

endmodule

// File: tb/tb_chip_link_tx.sv
module tb_chip_link_tx;
  localparam int FW          = 64;
  localparam int CONNECT     = 2;
  localparam int PW          = 16;
  localparam int SB          = 2;
  localparam int LINK_CREDIT = 4;
  localparam int SW          = (CONNECT > 1) ? $clog2(CONNECT) : 1;
  localparam int WW          = FW + SW;
  localparam int NP          = (WW + PW - 1) / PW;
  localparam int CW          = $clog2(LINK_CREDIT + 1);
  localparam int DEPTH       = 2 ** SB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data_out_wr = 1'b0;
  logic [WW-1:0] data_out = '0;
  logic          link_credit_in = 1'b0;
  logic          send_fifo_full, link_valid, link_sof, link_eof, link_err;
  logic [PW-1:0] link_phit;
  logic [CW-1:0] link_credit_cnt;

  chip_link_tx #(
    .FW(FW), .CONNECT(CONNECT), .PW(PW), .SB(SB), .LINK_CREDIT(LINK_CREDIT)
  ) dut (
    .clk(clk), .reset(reset),
    .data_out_wr(data_out_wr), .data_out(data_out),
    .send_fifo_full(send_fifo_full),
    .link_valid(link_valid), .link_sof(link_sof), .link_eof(link_eof), .link_phit(link_phit),
    .link_credit_in(link_credit_in), .link_credit_cnt(link_credit_cnt), .link_err(link_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue, a queue of phits still to appear, and a credit integer.
  logic [WW-1:0] m_fq[$];
  logic [PW-1:0] m_tx[$];
  bit            m_valid = 0, m_sof = 0, m_eof = 0, m_err = 0;
  logic [PW-1:0] m_phit = '0;
  int            m_credit = LINK_CREDIT;

  task automatic model_step();
    bit            start;
    int            occ;
    logic [WW-1:0] w;
    if (reset) begin
      m_fq.delete();
      m_tx.delete();
      m_valid = 0; m_sof = 0; m_eof = 0; m_err = 0;
      m_phit = '0;
      m_credit = LINK_CREDIT;
      return;
    end
    occ = m_fq.size();
    if (!m_valid)              start = (occ > 0) && (m_credit > 0);
    else if (m_tx.size() == 0) start = (occ > 0) && (m_credit > 0 || link_credit_in);
    else                       start = 0;
    if (m_valid && m_tx.size() > 0) begin
      m_phit = m_tx.pop_front();
      m_sof  = 0;
      m_eof  = (m_tx.size() == 0);
    end else if (start) begin
      w = m_fq.pop_front();
      for (int k = 0; k < NP; k++) m_tx.push_back(PW'(w >> (k * PW)));
      m_phit  = m_tx.pop_front();
      m_valid = 1;
      m_sof   = 1;
      m_eof   = (m_tx.size() == 0);
    end else begin
      m_valid = 0; m_sof = 0; m_eof = 0;
    end
    if (link_credit_in && !start) begin
      if (m_credit == LINK_CREDIT) m_err = 1;
      else                         m_credit++;
    end else if (start && !link_credit_in) begin
      m_credit--;
    end
    if (data_out_wr) begin
      if (occ == DEPTH) m_err = 1;
      else              m_fq.push_back(data_out);
    end
  endtask

  int cyc = 0, cnt_valid = 0, cnt_sof = 0, first_v = -1, last_v = -1;

  task automatic clr();
    cnt_valid = 0; cnt_sof = 0; first_v = -1; last_v = -1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("m_valid",  64'(link_valid), 64'(m_valid));
    check("m_sof",    64'(link_sof), 64'(m_sof));
    check("m_eof",    64'(link_eof), 64'(m_eof));
    check("m_phit",   64'(link_phit), 64'(m_phit));
    check("m_credit", 64'(link_credit_cnt), 64'(m_credit));
    check("m_err",    64'(link_err), 64'(m_err));
    check("m_full",   64'(send_fifo_full), 64'(m_fq.size() >= DEPTH - 1));
    if (link_valid) begin
      cnt_valid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (link_sof) cnt_sof++;
  endtask

  task automatic drive(input bit rst, input bit wr, input logic [WW-1:0] d, input bit cin);
    reset = rst; data_out_wr = wr; data_out = d; link_credit_in = cin;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[WW-1:0];
  endfunction

  typedef struct {
    bit            rst, wr, cin;
    logic [WW-1:0] d;
    bit            e_valid, e_sof, e_eof;
    logic [PW-1:0] e_phit;
    int            e_credit;
    bit            e_full, e_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vt[NV];

  function automatic vec_t mk(bit rst, bit wr, logic [WW-1:0] d, bit cin, bit v, bit s, bit e,
                              logic [PW-1:0] p, int cr, bit f, bit er);
    vec_t r;
    r.rst = rst; r.wr = wr; r.d = d; r.cin = cin;
    r.e_valid = v; r.e_sof = s; r.e_eof = e; r.e_phit = p;
    r.e_credit = cr; r.e_full = f; r.e_err = er;
    return r;
  endfunction

  initial begin
    logic [WW-1:0] w0;
    int wcyc;
    w0 = 65'h1_0123_4567_89AB_CDEF;
    vt[0]  = mk(1, 0, '0, 0, 0, 0, 0, 16'h0000, 4, 0, 0);
    vt[1]  = mk(0, 1, w0, 0, 0, 0, 0, 16'h0000, 4, 0, 0);
    vt[2]  = mk(0, 0, '0, 0, 1, 1, 0, 16'hCDEF, 3, 0, 0);
    vt[3]  = mk(0, 0, '0, 0, 1, 0, 0, 16'h89AB, 3, 0, 0);
    vt[4]  = mk(0, 0, '0, 0, 1, 0, 0, 16'h4567, 3, 0, 0);
    vt[5]  = mk(0, 0, '0, 0, 1, 0, 0, 16'h0123, 3, 0, 0);
    vt[6]  = mk(0, 0, '0, 0, 1, 0, 1, 16'h0001, 3, 0, 0);
    vt[7]  = mk(0, 0, '0, 0, 0, 0, 0, 16'h0001, 3, 0, 0);
    vt[8]  = mk(0, 0, '0, 1, 0, 0, 0, 16'h0001, 4, 0, 0);
    vt[9]  = mk(0, 0, '0, 1, 0, 0, 0, 16'h0001, 4, 0, 1);
    vt[10] = mk(1, 0, '0, 0, 0, 0, 0, 16'h0000, 4, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].wr, vt[i].d, vt[i].cin);
      check($sformatf("vec%0d_valid", i), 64'(link_valid), 64'(vt[i].e_valid));
      check($sformatf("vec%0d_sof", i), 64'(link_sof), 64'(vt[i].e_sof));
      check($sformatf("vec%0d_eof", i), 64'(link_eof), 64'(vt[i].e_eof));
      check($sformatf("vec%0d_phit", i), 64'(link_phit), 64'(vt[i].e_phit));
      check($sformatf("vec%0d_credit", i), 64'(link_credit_cnt), 64'(vt[i].e_credit));
      check($sformatf("vec%0d_full", i), 64'(send_fifo_full), 64'(vt[i].e_full));
      check($sformatf("vec%0d_err", i), 64'(link_err), 64'(vt[i].e_err));
    end

    // Four back-to-back writes with no credit returns. The first word is popped
    // one cycle after it lands, so occupancy reaches DEPTH-1 on the fourth write.
    drive(1, 0, '0, 0);
    clr();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, rnd_word(), 0);
      if (i == 1) check("burst_full_low", 64'(send_fifo_full), 64'(0));
      if (i == 3) check("burst_full_high", 64'(send_fifo_full), 64'(1));
    end
    idle(20);
    check("burst_valid_cycles", 64'(cnt_valid), 64'(20));
    check("burst_contiguous", 64'(last_v - first_v + 1), 64'(20));
    check("burst_words", 64'(cnt_sof), 64'(4));
    check("burst_credit0", 64'(link_credit_cnt), 64'(0));
    check("burst_idle", 64'(link_valid), 64'(0));
    check("burst_fifo_empty", 64'(send_fifo_full), 64'(0));

    // Credit starved with two words queued, then a single credit returned.
    clr();
    drive(0, 1, rnd_word(), 0);
    drive(0, 1, rnd_word(), 0);
    idle(10);
    check("starved_no_valid", 64'(cnt_valid), 64'(0));
    clr();
    drive(0, 0, '0, 1);
    idle(20);
    check("one_credit_phits", 64'(cnt_valid), 64'(NP));
    check("one_credit_words", 64'(cnt_sof), 64'(1));
    check("one_credit_stall", 64'(link_valid), 64'(0));
    check("one_credit_cnt", 64'(link_credit_cnt), 64'(0));

    // Credit return coinciding with a first-phit launch at credit 2.
    drive(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, rnd_word(), 0);
    idle(8);
    check("coinc_before", 64'(link_credit_cnt), 64'(2));
    drive(0, 0, '0, 1);
    check("coinc_launch", 64'(link_sof), 64'(1));
    check("coinc_credit", 64'(link_credit_cnt), 64'(2));
    idle(8);

    // Overflow: stall the link, then push five words ignoring send_fifo_full.
    drive(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, rnd_word(), 0);
    idle(20);
    for (int i = 0; i < 4; i++) drive(0, 1, rnd_word(), 0);
    check("ovf_err_before", 64'(link_err), 64'(0));
    check("ovf_full", 64'(send_fifo_full), 64'(1));
    drive(0, 1, rnd_word(), 0);
    check("ovf_err_set", 64'(link_err), 64'(1));
    clr();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, '0, 1);
      idle(6);
    end
    check("ovf_retained", 64'(cnt_sof), 64'(4));
    check("ovf_drained", 64'(send_fifo_full), 64'(0));
    check("ovf_err_sticky", 64'(link_err), 64'(1));

    // Reset while the third phit of a word is on the link, with more words queued.
    drive(1, 0, '0, 0);
    drive(0, 1, w0, 0);
    drive(0, 1, rnd_word(), 0);
    drive(0, 1, rnd_word(), 0);
    idle(1);
    check("midrst_phit3", 64'(link_phit), 64'(16'h4567));
    drive(1, 0, '0, 0);
    check("midrst_valid", 64'(link_valid), 64'(0));
    check("midrst_credit", 64'(link_credit_cnt), 64'(LINK_CREDIT));
    check("midrst_full", 64'(send_fifo_full), 64'(0));
    clr();
    idle(4);
    check("midrst_flushed", 64'(cnt_valid), 64'(0));
    clr();
    drive(0, 1, w0, 0);
    wcyc = cyc;
    idle(7);
    check("midrst_new_phits", 64'(cnt_valid), 64'(NP));
    check("midrst_new_first", 64'(first_v), 64'(wcyc + 1));
    check("midrst_new_words", 64'(cnt_sof), 64'(1));

    // Randomised traffic against the reference model.
    drive(1, 0, '0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit rst, wr, cin;
      rst = ($urandom_range(0, 799) == 0);
      if (send_fifo_full) wr = ($urandom_range(0, 9) == 0);
      else                wr = ($urandom_range(0, 1) == 1);
      cin = ($urandom_range(0, 5) == 0);
      drive(rst, wr, rnd_word(), cin);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
